// File: rtl/queue_b.sv
// Button-driven FIFO queue with debounced edge-pulse enqueue/dequeue.
// Optional macro QUEUE_OVERWRITE_EN: push on full overwrites the oldest entry.
module queue_b #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             push_btn,
  input  logic             pop_btn,
  output logic [WIDTH-1:0] Dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      Count
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic             r_push_s1;
  logic             r_push_s2;
  logic             r_push_lock;
  logic             r_pop_s1;
  logic             r_pop_s2;
  logic             r_pop_lock;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_dout;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_we;
  logic [AW-1:0]    w_wp_n;
  logic [AW-1:0]    w_rp_n;
  logic [AW:0]      w_cnt_n;
  logic [WIDTH-1:0] w_dout_n;

  // Lock is set by reset and only drops once the raw button is seen low,
  // so a press held across reset release never fires.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_push_s1   <= 1'b0;
      r_push_s2   <= 1'b0;
      r_push_lock <= 1'b1;
      r_pop_s1    <= 1'b0;
      r_pop_s2    <= 1'b0;
      r_pop_lock  <= 1'b1;
    end else begin
      r_push_s1 <= push_btn;
      r_push_s2 <= r_push_s1;
      r_pop_s1  <= pop_btn;
      r_pop_s2  <= r_pop_s1;
      if (!push_btn) r_push_lock <= 1'b0;
      if (!pop_btn)  r_pop_lock  <= 1'b0;
    end
  end

  assign w_push  = r_push_s1 & ~r_push_s2 & ~r_push_lock;
  assign w_pop   = r_pop_s1  & ~r_pop_s2  & ~r_pop_lock;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FULL_CNT);

  always_comb begin
    w_we    = 1'b0;
    w_wp_n  = r_wp;
    w_rp_n  = r_rp;
    w_cnt_n = r_cnt;
    unique case ({w_push, w_pop})
      2'b10: begin
        if (!w_full) begin
          w_we    = 1'b1;
          w_wp_n  = r_wp + PTR_ONE;
          w_cnt_n = r_cnt + CNT_ONE;
        end
`ifdef QUEUE_OVERWRITE_EN
        else begin
          w_we   = 1'b1;
          w_wp_n = r_wp + PTR_ONE;
          w_rp_n = r_rp + PTR_ONE;
        end
`else
        else begin
          w_we = 1'b0;
        end
`endif
      end
      2'b01: begin
        if (!w_empty) begin
          w_rp_n  = r_rp + PTR_ONE;
          w_cnt_n = r_cnt - CNT_ONE;
        end
      end
      2'b11: begin
        w_we   = 1'b1;
        w_wp_n = r_wp + PTR_ONE;
        if (w_empty) w_cnt_n = CNT_ONE;
        else         w_rp_n  = r_rp + PTR_ONE;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  // Head comes from Din when this edge writes the slot it lands on.
  always_comb begin
    w_dout_n = '0;
    if (w_cnt_n != '0) begin
      if (w_we && (w_rp_n == r_wp)) w_dout_n = Din;
      else                          w_dout_n = r_mem[w_rp_n];
    end
  end

  always_ff @(negedge clk) begin
    if (!reset && w_we) r_mem[r_wp] <= Din;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
    end else begin
      r_wp   <= w_wp_n;
      r_rp   <= w_rp_n;
      r_cnt  <= w_cnt_n;
      r_dout <= w_dout_n;
    end
  end

  assign Dout  = r_dout;
  assign Count = r_cnt;
  assign empty = w_empty;
  assign full  = w_full;

endmodule
